// File: rtl/tile_game_ctrl.sv
// Four-column falling-tile game: debounced keys, LFSR tile spawner, and the
// START/PLAY/OVER controller that owns the field and the score.
module tile_game_ctrl #(
  parameter int unsigned STEP_CYCLES     = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter logic [2:0]  TILE_COLOR      = 3'b001
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic [3:0]  key_n,
  input  logic        start_n,
  output logic [1:0]  game_state,
  output logic [7:0]  score,
  output logic [23:0] column_0,
  output logic [23:0] column_1,
  output logic [23:0] column_2,
  output logic [23:0] column_3
);
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {S_START = 2'b00, S_PLAY = 2'b01, S_OVER = 2'b10} state_t;

  logic [3:0]         key_s1_q, key_s2_q, key_smp_q;
  logic               st_s1_q, st_s2_q, st_smp_q;
  logic [DW-1:0]      dcnt_q;
  logic [7:0]         lfsr_q;
  logic [SW-1:0]      scnt_q, scnt_d;
  state_t             state_q, state_d;
  logic [7:0]         score_q, score_d;
  logic [3:0][23:0]   cols_q, cols_d, cols_k;

  logic               smp_wrap, step_wrap, start_press, multi, field_empty, key_ovr, bottom;
  logic [3:0]         key_press;
  logic [1:0]         tgt_col;
  logic [4:0]         tgt_lsb;

  assign smp_wrap    = (dcnt_q == D_LAST);
  assign step_wrap   = (scnt_q == S_LAST);
  // A press is a 1 -> 0 transition of the sampled level, seen only on a sample tick.
  assign key_press   = {4{smp_wrap}} & key_smp_q & ~key_s2_q;
  assign start_press = smp_wrap & st_smp_q & ~st_s2_q;
  assign multi       = (key_press & (key_press - 4'd1)) != 4'd0;
  assign field_empty = (cols_q == '0);

  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      key_s1_q  <= 4'hF;
      key_s2_q  <= 4'hF;
      key_smp_q <= 4'hF;
      st_s1_q   <= 1'b1;
      st_s2_q   <= 1'b1;
      st_smp_q  <= 1'b1;
      dcnt_q    <= '0;
      lfsr_q    <= 8'h01;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      st_s1_q  <= start_n;
      st_s2_q  <= st_s1_q;
      dcnt_q   <= smp_wrap ? '0 : dcnt_q + 1'b1;
      if (smp_wrap) begin
        key_smp_q <= key_s2_q;
        st_smp_q  <= st_s2_q;
      end
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Target is the lowest occupied row; later (lower) rows overwrite earlier hits.
  always_comb begin
    tgt_col = '0;
    tgt_lsb = 5'd21;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        if (cols_q[c][(21 - 3*r) +: 3] != 3'b000) begin
          tgt_col = 2'(c);
          tgt_lsb = 5'(21 - 3*r);
        end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    cols_d  = cols_q;
    scnt_d  = scnt_q;
    cols_k  = cols_q;
    key_ovr = 1'b0;
    bottom  = 1'b0;
    case (state_q)
      S_START: begin
        if (start_press) begin
          state_d = S_PLAY;
          score_d = '0;
          cols_d  = '0;
          scnt_d  = '0;
        end
      end
      S_PLAY: begin
        scnt_d = step_wrap ? '0 : scnt_q + 1'b1;
        if (key_press != 4'd0) begin
          if (multi || field_empty || !key_press[tgt_col]) begin
            key_ovr = 1'b1;
          end else begin
            cols_k[tgt_col][tgt_lsb +: 3] = 3'b000;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          end
        end
        for (int c = 0; c < 4; c++) bottom = bottom | (cols_k[c][2:0] != 3'b000);
        // Key outcome lands first; the step then acts on the post-key field.
        if (key_ovr) begin
          state_d = S_OVER;
          score_d = score_q;
        end else begin
          cols_d = cols_k;
          if (step_wrap) begin
            if (bottom) state_d = S_OVER;
            else
              for (int c = 0; c < 4; c++)
                cols_d[c] = {(lfsr_q[1:0] == 2'(c)) ? TILE_COLOR : 3'b000, cols_k[c][23:3]};
          end
        end
      end
      S_OVER: begin
        if (start_press) begin
          state_d = S_START;
          cols_d  = '0;
        end
      end
      default: begin
        state_d = S_START;
        cols_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      state_q <= S_START;
      score_q <= '0;
      cols_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      cols_q  <= cols_d;
      scnt_q  <= scnt_d;
    end
  end

  assign game_state = state_q;
  assign score      = score_q;
  assign column_0   = cols_q[0];
  assign column_1   = cols_q[1];
  assign column_2   = cols_q[2];
  assign column_3   = cols_q[3];
endmodule

// File: tb/tb_tile_game_ctrl.sv
// Scoreboard bench for tile_game_ctrl: stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the outputs.
module tb_tile_game_ctrl;
  localparam logic [1:0] ST_START = 2'b00, ST_PLAY = 2'b01, ST_OVER = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_n = 4'hF;
  logic        start_n = 1'b1;
  logic [1:0]  game_state;
  logic [7:0]  score;
  logic [23:0] column_0, column_1, column_2, column_3;

  tile_game_ctrl #(.STEP_CYCLES(4), .DEBOUNCE_CYCLES(1), .TILE_COLOR(3'b001)) dut (
    .CLK_50M(clk), .RST_N(rst_n), .key_n(key_n), .start_n(start_n),
    .game_state(game_state), .score(score),
    .column_0(column_0), .column_1(column_1), .column_2(column_2), .column_3(column_3)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    int               due;
    logic [1:0]       st;
    logic [7:0]       sc;
    logic [3:0][23:0] cols;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] lfsr_m;

  // Expected game state, advanced one clock edge at a time by tick().
  logic [1:0]       es;
  logic [7:0]       esc;
  logic [3:0][23:0] ec;
  int               P;
  int               key_due = -1;
  int               start_due = -1;
  logic [3:0]       key_vec;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) lfsr_m <= 8'h01;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  initial forever begin
    @(negedge clk);
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.due != cyc) begin
        failures++;
        $display("FAIL %s: expectation due at cycle %0d not checked until %0d", e.name, e.due, cyc);
      end else if (game_state !== e.st || score !== e.sc ||
                   {column_3, column_2, column_1, column_0} !== e.cols) begin
        failures++;
        $display("FAIL %s: got state=%b score=%0d cols=%h_%h_%h_%h required state=%b score=%0d cols=%h_%h_%h_%h",
                 e.name, game_state, score, column_3, column_2, column_1, column_0,
                 e.st, e.sc, e.cols[3], e.cols[2], e.cols[1], e.cols[0]);
      end
    end
  end

  // Lowest occupied cell, scanning upward from the bottom row.
  task automatic find_tgt(output int row, output int col);
    row = -1;
    col = -1;
    for (int r = 7; r >= 0 && col < 0; r--)
      for (int c = 0; c < 4; c++)
        if (col < 0 && ((ec[c] >> (3 * (7 - r))) & 24'h7) != 24'h0) begin
          row = r;
          col = c;
        end
  endtask

  task automatic m_key(input logic [3:0] v);
    int r, c;
    if (es != ST_PLAY) return;
    find_tgt(r, c);
    if ($countones(v) > 1 || c < 0) es = ST_OVER;
    else if (!v[c]) es = ST_OVER;
    else begin
      ec[c] = ec[c] & ~(24'h7 << (3 * (7 - r)));
      if (esc != 8'hFF) esc = esc + 8'd1;
    end
  endtask

  task automatic m_step();
    logic [1:0] sel;
    sel = lfsr_m[1:0];
    if ((ec[0][2:0] | ec[1][2:0] | ec[2][2:0] | ec[3][2:0]) != 3'b000) begin
      es = ST_OVER;
      return;
    end
    for (int c = 0; c < 4; c++) ec[c] = ec[c] >> 3;
    ec[sel][23:21] = 3'b001;
  endtask

  task automatic m_start();
    if (es == ST_START) begin
      es = ST_PLAY; esc = 8'd0; ec = '0; P = cyc + 1;
    end else if (es == ST_OVER) begin
      es = ST_START; ec = '0;
    end
  endtask

  // Called at a negedge: predicts the effect of the coming posedge, then crosses it.
  task automatic tick();
    if (!rst_n) begin
      es = ST_START; esc = 8'd0; ec = '0; key_due = -1; start_due = -1;
    end else begin
      if (key_due == cyc + 1) m_key(key_vec);
      if (start_due == cyc + 1) m_start();
      if (es == ST_PLAY && cyc + 1 > P && ((cyc + 1 - P) % 4) == 0) m_step();
    end
    @(negedge clk);
    key_n = 4'hF;
    start_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic press_key(input logic [3:0] v);
    key_n = ~v; key_vec = v; key_due = cyc + 3;
    tick();
  endtask

  task automatic press_start();
    start_n = 1'b0; start_due = cyc + 3;
    tick();
  endtask

  task automatic hit_target();
    int r, c;
    find_tgt(r, c);
    press_key(4'(1 << ((c < 0) ? 0 : c)));
  endtask

  task automatic chk(input string nm);
    exp_t e;
    e.name = nm; e.due = cyc; e.st = es; e.sc = esc; e.cols = ec;
    q.push_back(e);
  endtask

  initial begin
    int r, c;
    es = ST_START; esc = 8'd0; ec = '0; P = 0; key_vec = 4'h0;
    @(negedge clk);
    run(3);                       chk("reset_state");
    rst_n = 1'b1; run(3);         chk("idle_after_reset");

    press_start(); run(2);        chk("play_entry");
    run(4);                       chk("first_step_tile");
    run(28);                      chk("tile_at_bottom");
    run(4);                       chk("miss_over");
    run(6);                       chk("over_frozen");
    press_key(4'b0001); run(3);   chk("key_in_over");
    press_start(); run(2);        chk("over_to_start");

    press_start(); run(6);
    hit_target(); run(3);         chk("hit_score1");
    find_tgt(r, c);
    press_key(4'(1 << ((c + 1) % 4))); run(3); chk("wrong_key_over");
    press_start(); run(2);        chk("start_keeps_score");

    press_start(); run(6);
    press_key(4'b0011); run(3);   chk("two_keys_over");
    press_start(); run(2);
    press_start(); run(2);
    press_key(4'b0100); run(3);   chk("empty_field_key_over");
    press_start(); run(2);

    press_start(); run(2); run(7);
    for (int i = 0; i < 256; i++) begin
      hit_target(); run(3);
      if (i == 0)   chk("sat_first_hit");
      if (i == 254) chk("score_255");
      if (i == 255) chk("score_saturated");
    end
    press_key(4'b1111); run(3);
    press_start(); run(2);

    press_start(); run(2); run(33);
    hit_target(); run(2);         chk("hit_on_step_at_bottom");
    run(4);                       chk("next_bottom_miss");
    press_start(); run(2);

    press_start(); run(6);
    hit_target(); run(3);
    rst_n = 1'b0; tick(); rst_n = 1'b1; chk("mid_play_reset");
    run(3);                       chk("idle_after_mid_reset");

    press_start(); run(2);
    press_key(4'b0001); run(3);   chk("pre_bounce_over");
    start_n = 1'b0; #1 start_n = 1'b1; #1 start_n = 1'b0; #1 start_n = 1'b1; #1 start_n = 1'b0;
    start_due = cyc + 3; tick();
    run(6);                       chk("bounce_single_press");

    run(3);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tile_game_ctrl.md
TILE_GAME_CTRL -- requirements
Module: tile_game_ctrl

Interface
REQ-001 Parameter STEP_CYCLES, default 25_000_000: clock cycles per scroll step (0.5 s at 50 MHz).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500_000: key sample period in clock cycles (10 ms).
REQ-003 Parameter TILE_COLOR, default 3'b001: colour code of a live tile; 3'b000 is an empty cell.
REQ-004 CLK_50M  in  1  sole clock; all logic on its rising edge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 key_n  in  4  raw active-low column buttons, bit k = column k, asynchronous to CLK_50M.
REQ-007 start_n  in  1  raw active-low start button, asynchronous.
REQ-008 game_state  out  2  00 START, 01 PLAY, 10 OVER; registered.
REQ-009 score  out  8  tiles hit this game; registered.
REQ-010 column_0..column_3  out  24 each  column k cells; bits [23:21] = row 0 (top) ... bits [2:0] = row 7 (bottom); 3 bits per cell; registered.

Function
REQ-011 Each of key_n[3:0] and start_n SHALL pass through a 2-flop synchronizer.
REQ-012 A sample counter SHALL wrap every DEBOUNCE_CYCLES; on wrap, synchronized buttons are latched into a sampled register.
REQ-013 A press event SHALL be a single-cycle pulse on the wrap cycle where the sampled value goes 1 -> 0; releases generate nothing.
REQ-014 An 8-bit Fibonacci LFSR (taps 8,6,5,4), non-zero, SHALL advance every cycle; its bits [1:0] select the new-tile column.
REQ-015 START: all columns 0; score held. Start press -> PLAY, score <= 0, columns <= 0, step counter <= 0.
REQ-016 PLAY: step counter counts 0..STEP_CYCLES-1 and wraps; the wrap cycle is a step.
REQ-017 On a step, if any column bits [2:0] are non-zero -> OVER, columns frozen (missed tile).
REQ-018 On a step with no bottom tile, each column SHALL shift down one row (col >> 3), and row 0 of the LFSR-selected column is loaded with TILE_COLOR; other row-0 cells are 0.
REQ-019 Target tile = lowest occupied row across all columns; at most one tile per row by construction.
REQ-020 Single key press on target column SHALL clear that cell and increment score, saturating at 255.
REQ-021 Key press on a non-target column, or with the field empty -> OVER, field and score frozen.
REQ-022 Two or more key press events in the same cycle -> OVER.
REQ-023 Key and step in the same cycle: key is resolved first; the step's miss check and shift use the post-key field; a key-induced OVER suppresses the step.
REQ-024 Start presses in PLAY SHALL be ignored.
REQ-025 OVER: outputs held; start press -> START (columns cleared, score held until next PLAY entry); key presses ignored.
REQ-026 game_state 11 SHALL transition to START on the next cycle.
REQ-027 Output changes SHALL appear the cycle after the triggering event (1-cycle latency).

Reset
REQ-028 While RST_N=0 at a clock edge: game_state=00, score=0, all columns=0, counters=0, synchronizer/sampled flops=1, LFSR=8'h01; applies mid-game too.
REQ-029 Deasserting RST_N SHALL resume normal operation on the next edge with no spurious press event.

Verification (STEP_CYCLES=4, DEBOUNCE_CYCLES=1)
REQ-030 Reset, start_n pulsed low -> game_state=01, score=0, columns=0; first step puts 24'h200000 (TILE_COLOR in row 0) in exactly one column.
REQ-031 No keys for 8 steps -> 8th-row tile reaches bits [2:0]; next step -> game_state=10, columns frozen.
REQ-032 Press target column key before the tile reaches the bottom -> cell cleared, score=1; wrong column press -> game_state=10, score unchanged.
REQ-033 Two keys pressed same sample -> game_state=10; key press in OVER -> no change; start press -> game_state=00, columns=0.
REQ-034 Force 255 hits -> score stays 255 after 256th hit; key hit on target coinciding with step when tile is at bottom -> no OVER, shift proceeds.
REQ-035 RST_N low mid-PLAY for one edge -> all outputs reset values next cycle; bouncing start_n within one sample period -> one press event only.
